// File: rtl/uart_route_pkg.sv
// Shared types and helpers for the FPGA UART routing blocks
// (uart_router and uart_return_arbiter).
package uart_route_pkg;

    typedef enum logic {
        SRC_CROC = 1'b0,
        SRC_STM  = 1'b1
    } src_id_e;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } arb_state_e;

    localparam logic [7:0] HEADER_BASE_DEFAULT = 8'hA0;

    function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud);
        return clk / baud;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer with a valid/ready byte input; ready only while idle,
// so back-to-back bytes leave exactly one idle-high cycle between frames.
module uart_tx_core #(
    parameter int unsigned BaudDiv = 160
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int unsigned CW = $clog2(BaudDiv);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BaudDiv - 1);

    logic          busy_q, busy_d;
    logic          tx_q, tx_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [8:0]    shreg_q, shreg_d;

    // bit_idx 0 is the start bit, 1..8 data, 9 the stop bit
    always_comb begin
        busy_d     = busy_q;
        tx_d       = tx_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        if (!busy_q) begin
            if (valid_i) begin
                busy_d     = 1'b1;
                tx_d       = 1'b0;
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                shreg_d    = {1'b1, data_i};
            end
        end else if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_d = '0;
            if (bit_idx_q == 4'd9) begin
                busy_d = 1'b0;
            end else begin
                tx_d      = shreg_q[0];
                shreg_d   = {1'b1, shreg_q[8:1]};
                bit_idx_d = bit_idx_q + 4'd1;
            end
        end else begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q     <= 1'b0;
            tx_q       <= 1'b1;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '1;
        end else begin
            busy_q     <= busy_d;
            tx_q       <= tx_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
        end
    end

    assign ready_o = ~busy_q;
    assign tx_o    = tx_q;

endmodule

// File: rtl/uart_return_arbiter.sv
// Merges CROC and STM32 byte streams onto the PC UART TX line, prefixing
// each frame with a source tag byte; round-robin per frame with burst cap and gap close.
module uart_return_arbiter
    import uart_route_pkg::*;
#(
    parameter int unsigned ClkFreq    = 20000000,
    parameter int unsigned BaudRate   = 125000,
    parameter logic [7:0]  HeaderBase = HEADER_BASE_DEFAULT,
    parameter int unsigned MaxBurst   = 64,
    parameter int unsigned GapCycles  = 3200
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [1:0][7:0] src_data_i,
    input  logic [1:0]      src_valid_i,
    input  logic [1:0]      src_last_i,
    output logic [1:0]      src_ready_o,
    output logic            uart_tx_o,
    output logic            busy_o,
    output logic            grant_o
);

    localparam int unsigned BaudDiv = baud_div(ClkFreq, BaudRate);
    localparam int unsigned BW      = $clog2(MaxBurst + 1);
    localparam int unsigned GW      = $clog2(GapCycles + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MaxBurst);
    localparam logic [GW-1:0] GAP_MAX   = GW'(GapCycles);

    if (BaudDiv < 2 || BaudDiv * BaudRate != ClkFreq) begin : g_baud_check
        $error("uart_return_arbiter: ClkFreq/BaudRate must be an integer of at least 2");
    end

    arb_state_e    state_q, state_d;
    src_id_e       grant_q, grant_d;
    src_id_e       rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d, byte_inc;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d, gap_inc;

    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    assign byte_inc = (byte_cnt_q == BURST_MAX) ? byte_cnt_q : byte_cnt_q + 1'b1;
    assign gap_inc  = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tx_valid    = 1'b0;
        tx_data     = HeaderBase | {7'b0, grant_q};
        src_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (|src_valid_i) begin
                    grant_d = src_valid_i[rr_ptr_q] ? rr_ptr_q : src_id_e'(~rr_ptr_q);
                    state_d = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_d    = DATA;
                    byte_cnt_d = '0;
                    gap_cnt_d  = '0;
                end
            end
            DATA: begin
                src_ready_o[grant_q] = tx_ready;
                tx_valid             = src_valid_i[grant_q];
                tx_data              = src_data_i[grant_q];
                // Frame closes on last, burst cap or idle gap; all hand priority to the other source
                if (src_valid_i[grant_q] && tx_ready) begin
                    byte_cnt_d = byte_inc;
                    gap_cnt_d  = '0;
                    if (src_last_i[grant_q] || byte_inc == BURST_MAX) begin
                        state_d  = IDLE;
                        rr_ptr_d = src_id_e'(~grant_q);
                    end
                end else if (!src_valid_i[grant_q]) begin
                    gap_cnt_d = gap_inc;
                    if (gap_inc == GAP_MAX) begin
                        state_d  = IDLE;
                        rr_ptr_d = src_id_e'(~grant_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            grant_q    <= SRC_CROC;
            rr_ptr_q   <= SRC_CROC;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    uart_tx_core #(
        .BaudDiv (BaudDiv)
    ) u_tx (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (tx_data),
        .valid_i (tx_valid),
        .ready_o (tx_ready),
        .tx_o    (uart_tx_o)
    );

    assign busy_o  = (state_q != IDLE) || !tx_ready;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_uart_return_arbiter.sv
// Directed bench for uart_return_arbiter: queue-fed sources, a line decoder,
// and a linear sequence of steps with immediate-assertion checks.
module tb_uart_return_arbiter;

    localparam int unsigned B     = 4;
    localparam int unsigned FRAME = 10 * B;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0][7:0] src_data;
    logic [1:0]      src_valid;
    logic [1:0]      src_last;
    logic [1:0]      src_ready_o;
    logic            uart_tx_o;
    logic            busy_o;
    logic            grant_o;

    int unsigned cyc = 0;
    int unsigned n_assert = 0;
    int unsigned n_fail = 0;

    typedef struct packed {logic [7:0] data; logic last;} item_t;
    typedef struct packed {logic [7:0] data; logic [31:0] start; logic stop_ok;} rx_t;
    item_t q0[$];
    item_t q1[$];
    rx_t   rxq[$];
    logic [1:0] hs;

    uart_return_arbiter #(
        .ClkFreq    (400000),
        .BaudRate   (100000),
        .HeaderBase (8'hA0),
        .MaxBurst   (4),
        .GapCycles  (100)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .src_data_i  (src_data),
        .src_valid_i (src_valid),
        .src_last_i  (src_last),
        .src_ready_o (src_ready_o),
        .uart_tx_o   (uart_tx_o),
        .busy_o      (busy_o),
        .grant_o     (grant_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Source driver: presents queue heads, pops after each observed handshake
    initial begin
        src_valid = '0;
        src_data  = '0;
        src_last  = '0;
        forever begin
            @(negedge clk);
            hs = src_valid & src_ready_o;
            @(posedge clk);
            #1;
            if (hs[0] && q0.size() > 0) void'(q0.pop_front());
            if (hs[1] && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
                src_valid[0] = 1'b1; src_data[0] = q0[0].data; src_last[0] = q0[0].last;
            end else begin
                src_valid[0] = 1'b0; src_data[0] = 8'h00; src_last[0] = 1'b0;
            end
            if (q1.size() > 0) begin
                src_valid[1] = 1'b1; src_data[1] = q1[0].data; src_last[1] = q1[0].last;
            end else begin
                src_valid[1] = 1'b0; src_data[1] = 8'h00; src_last[1] = 1'b0;
            end
        end
    end

    // Line decoder: start cycle is the first cycle the line is low
    initial begin
        logic       prev;
        logic [7:0] d;
        int unsigned st;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !uart_tx_o) begin
                st = cyc;
                repeat (B + B / 2) @(negedge clk);
                d[0] = uart_tx_o;
                for (int i = 1; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    d[i] = uart_tx_o;
                end
                repeat (B) @(negedge clk);
                rxq.push_back('{data: d, start: st, stop_ok: uart_tx_o});
            end
            prev = uart_tx_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout, required end of sequence");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic l);
        if (s == 0) q0.push_back('{data: d, last: l});
        else        q1.push_back('{data: d, last: l});
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] exp, output int unsigned st);
        rx_t r;
        int unsigned waited;
        waited = 0;
        st = 0;
        while (rxq.size() == 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        n_assert++;
        assert (rxq.size() > 0) else begin
            n_fail++;
            $error("FAIL %s: observed no byte required 0x%0h", tag, exp);
        end
        if (rxq.size() > 0) begin
            r  = rxq.pop_front();
            st = r.start;
            check(tag, {24'h0, r.data}, {24'h0, exp});
            check({tag, "_stop"}, {31'h0, r.stop_ok}, 32'h1);
        end
    endtask

    task automatic wait_hs(input int s, output int unsigned t);
        int unsigned waited;
        waited = 0;
        t = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(src_valid[s] && src_ready_o[s]) && waited < 3000);
        n_assert++;
        assert (src_valid[s] && src_ready_o[s]) else begin
            n_fail++;
            $error("FAIL handshake_src%0d: observed none required transfer", s);
        end
        t = cyc;
    endtask

    initial begin
        int unsigned r, k, t, s0, s1, s2, s3;

        // Reset with both sources already holding 1-byte frames
        rst = 1'b1;
        push(0, 8'h11, 1'b1);
        push(1, 8'h22, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_tx", {31'h0, uart_tx_o}, 32'h1);
        check("rst_ready", {30'h0, src_ready_o}, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_grant", {31'h0, grant_o}, 32'h0);
        rst = 1'b0;
        r = cyc;

        // Contention: src0 first, then src1
        expect_rx("cont_hdr0", 8'hA0, s0);
        check("cont_hdr0_time", s0, r + 2);
        expect_rx("cont_d0", 8'h11, s1);
        check("cont_d0_time", s1, s0 + FRAME + 1);
        expect_rx("cont_hdr1", 8'hA1, s2);
        check("cont_hdr1_time", s2, s1 + FRAME + 1);
        check("cont_grant1", {31'h0, grant_o}, 32'h1);
        expect_rx("cont_d1", 8'h22, s3);
        wait_until(s3 + FRAME + 2);
        check("cont_idle", {31'h0, busy_o}, 32'h0);

        push(0, 8'h11, 1'b1);
        push(1, 8'h22, 1'b1);
        expect_rx("cont2_hdr0", 8'hA0, s0);
        expect_rx("cont2_d0", 8'h11, s1);
        expect_rx("cont2_hdr1", 8'hA1, s2);
        expect_rx("cont2_d1", 8'h22, s3);
        wait_until(s3 + FRAME + 2);

        // Single frame with latency and idle boundary
        k = cyc;
        push(0, 8'h55, 1'b0);
        push(0, 8'h3C, 1'b1);
        expect_rx("sf_hdr", 8'hA0, s0);
        check("sf_hdr_time", s0, k + 3);
        check("sf_grant", {31'h0, grant_o}, 32'h0);
        expect_rx("sf_d0", 8'h55, s1);
        check("sf_d0_time", s1, s0 + FRAME + 1);
        expect_rx("sf_d1", 8'h3C, s2);
        check("sf_d1_time", s2, s1 + FRAME + 1);
        wait_until(s2 + FRAME - 1);
        check("sf_busy_stop", {31'h0, busy_o}, 32'h1);
        wait_until(s2 + FRAME);
        check("sf_idle", {31'h0, busy_o}, 32'h0);
        check("sf_grant_after", {31'h0, grant_o}, 32'h0);

        // Stall of 50 cycles mid-frame: no new header, line idles high
        wait_until(cyc + 5);
        k = cyc;
        push(0, 8'h96, 1'b0);
        wait_hs(0, t);
        check("st_accept_time", t, k + 43);
        wait_until(t + 45);
        check("st_line_idle", {31'h0, uart_tx_o}, 32'h1);
        check("st_busy", {31'h0, busy_o}, 32'h1);
        wait_until(t + 50);
        push(0, 8'h4B, 1'b1);
        expect_rx("st_hdr", 8'hA0, s0);
        expect_rx("st_d0", 8'h96, s1);
        check("st_d0_time", s1, t + 1);
        expect_rx("st_d1", 8'h4B, s2);
        check("st_d1_time", s2, t + 52);
        wait_until(s2 + FRAME + 1);
        check("st_idle", {31'h0, busy_o}, 32'h0);
        check("st_no_extra", rxq.size(), 0);

        // Gap timeout closes the frame; next byte gets a fresh header
        k = cyc;
        push(0, 8'h3A, 1'b0);
        wait_hs(0, t);
        wait_until(t + 100);
        check("gap_busy_before", {31'h0, busy_o}, 32'h1);
        wait_until(t + 101);
        check("gap_closed", {31'h0, busy_o}, 32'h0);
        wait_until(t + 150);
        push(0, 8'hC3, 1'b1);
        expect_rx("gap_hdr0", 8'hA0, s0);
        expect_rx("gap_d0", 8'h3A, s1);
        expect_rx("gap_hdr1", 8'hA0, s2);
        expect_rx("gap_d1", 8'hC3, s3);
        check("gap_grant", {31'h0, grant_o}, 32'h0);
        wait_until(s3 + FRAME + 1);

        // Burst cap of 4 on src1
        for (int i = 0; i < 6; i++) push(1, 8'hB0 + 8'(i), 1'b0);
        expect_rx("bu_hdr0", 8'hA1, s0);
        check("bu_grant", {31'h0, grant_o}, 32'h1);
        expect_rx("bu_b0", 8'hB0, s0);
        expect_rx("bu_b1", 8'hB1, s0);
        expect_rx("bu_b2", 8'hB2, s0);
        expect_rx("bu_b3", 8'hB3, s1);
        expect_rx("bu_hdr1", 8'hA1, s2);
        check("bu_hdr1_time", s2, s1 + FRAME + 1);
        expect_rx("bu_b4", 8'hB4, s0);
        expect_rx("bu_b5", 8'hB5, s3);
        wait_until(s3 + 99);
        check("bu_gap_busy", {31'h0, busy_o}, 32'h1);
        wait_until(s3 + 100);
        check("bu_gap_idle", {31'h0, busy_o}, 32'h0);

        // Reset during data bit 3 of a 0xA5 byte
        wait_until(cyc + 5);
        push(0, 8'hA5, 1'b1);
        wait_hs(0, t);
        wait_until(t + 18);
        check("rm_bit3_low", {31'h0, uart_tx_o}, 32'h0);
        rst = 1'b1;
        wait_until(t + 19);
        check("rm_tx", {31'h0, uart_tx_o}, 32'h1);
        check("rm_ready", {30'h0, src_ready_o}, 32'h0);
        check("rm_busy", {31'h0, busy_o}, 32'h0);
        rst = 1'b0;
        wait_until(t + 80);
        rxq.delete();
        q0.delete();
        q1.delete();
        k = cyc;
        push(0, 8'h77, 1'b1);
        expect_rx("rm_hdr", 8'hA0, s0);
        check("rm_hdr_time", s0, k + 3);
        expect_rx("rm_d0", 8'h77, s1);
        wait_until(s1 + FRAME + 1);
        check("rm_idle", {31'h0, busy_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
